// File: rtl/fifo_wr_arbiter_pkg.sv
// fifo_wr_arbiter_pkg: FSM encoding and width helper shared by the FIFO write arbiter.
package fifo_wr_arbiter_pkg;
  typedef enum logic {ST_IDLE = 1'b0, ST_GRANT = 1'b1} state_t;
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// rr_picker: first requester at or after ptr, wrapping from N-1 to 0.
module rr_picker #(
  parameter int N    = 4,
  parameter int ID_W = 2
) (
  input  logic [N-1:0]    i_req,
  input  logic [ID_W-1:0] i_ptr,
  output logic            o_found,
  output logic [ID_W-1:0] o_idx,
  output logic [N-1:0]    o_onehot
);
  // Scan highest offset first so the nearest requester wins the last assignment.
  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_req[(int'(i_ptr) + i) % N]) begin
        o_found = 1'b1;
        o_idx   = ID_W'((int'(i_ptr) + i) % N);
      end
    end
    o_onehot = o_found ? (N'(1) << o_idx) : '0;
  end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter sharing one FIFO write port among N_SRC sources.
module fifo_wr_arbiter
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int N_SRC     = 4,
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [N_SRC-1:0]             src_valid_i,
  input  logic [N_SRC*WIDTH-1:0]       src_data_i,
  output logic [N_SRC-1:0]             src_ready_o,
  input  logic                         fifo_full_i,
  input  logic                         fifo_afull_i,
  output logic                         fifo_wr_dv_o,
  output logic [WIDTH-1:0]             fifo_wr_data_o,
  output logic [N_SRC-1:0]             grant_o,
  output logic [clog2_min1(N_SRC)-1:0] grant_id_o,
  output logic                         busy_o
);
  localparam int ID_W  = clog2_min1(N_SRC);
  localparam int CNT_W = clog2_min1(MAX_BURST + 1);

  state_t            r_state, w_state_nx;
  logic [N_SRC-1:0]  r_grant, w_grant_nx, w_pick_oh;
  logic [ID_W-1:0]   r_grant_id, w_grant_id_nx, r_rr_ptr, w_rr_ptr_nx, w_pick_idx, w_ptr_inc;
  logic [CNT_W-1:0]  r_beat_cnt, w_beat_cnt_nx;
  logic              w_found, w_xfer, w_regrant, w_burst_end;

  rr_picker #(.N(N_SRC), .ID_W(ID_W)) u_picker (
    .i_req    (src_valid_i),
    .i_ptr    (r_rr_ptr),
    .o_found  (w_found),
    .o_idx    (w_pick_idx),
    .o_onehot (w_pick_oh)
  );

  assign src_ready_o    = r_grant & {N_SRC{~fifo_full_i}};
  assign w_xfer         = |(src_valid_i & src_ready_o);
  assign fifo_wr_dv_o   = w_xfer;
  assign busy_o         = r_state == ST_GRANT;
  assign fifo_wr_data_o = busy_o ? src_data_i[r_grant_id*WIDTH +: WIDTH] : '0;
  assign grant_o        = r_grant;
  assign grant_id_o     = r_grant_id;
  assign w_regrant      = w_found & ~fifo_afull_i & ~fifo_full_i;
  assign w_burst_end    = ~src_valid_i[r_grant_id] | (w_xfer & (r_beat_cnt == CNT_W'(MAX_BURST - 1)));
  assign w_ptr_inc      = (w_pick_idx == ID_W'(N_SRC - 1)) ? '0 : w_pick_idx + 1'b1;

  // IDLE and burst end share one decision: re-grant directly or drop to IDLE.
  always_comb begin
    w_state_nx    = r_state;
    w_grant_nx    = r_grant;
    w_grant_id_nx = r_grant_id;
    w_rr_ptr_nx   = r_rr_ptr;
    w_beat_cnt_nx = r_beat_cnt + CNT_W'(w_xfer);
    if (r_state == ST_IDLE || w_burst_end) begin
      w_state_nx    = w_regrant ? ST_GRANT : ST_IDLE;
      w_grant_nx    = w_regrant ? w_pick_oh : '0;
      w_grant_id_nx = w_regrant ? w_pick_idx : '0;
      w_rr_ptr_nx   = w_regrant ? w_ptr_inc : r_rr_ptr;
      w_beat_cnt_nx = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= ST_IDLE;
      r_grant    <= '0;
      r_grant_id <= '0;
      r_rr_ptr   <= '0;
      r_beat_cnt <= '0;
    end else begin
      r_state    <= w_state_nx;
      r_grant    <= w_grant_nx;
      r_grant_id <= w_grant_id_nx;
      r_rr_ptr   <= w_rr_ptr_nx;
      r_beat_cnt <= w_beat_cnt_nx;
    end
  end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed and random stimulus against a cycle model plus per-source order scoreboard.
module tb_fifo_wr_arbiter;
  localparam int N = 4, W = 8, MB = 4;

  logic           clk = 1'b0, rst, full, afull, dv, busy;
  logic [N-1:0]   valid, ready, grant;
  logic [N*W-1:0] data;
  logic [W-1:0]   wdata;
  logic [1:0]     gid;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.N_SRC(N), .WIDTH(W), .MAX_BURST(MB)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .src_valid_i    (valid),
    .src_data_i     (data),
    .src_ready_o    (ready),
    .fifo_full_i    (full),
    .fifo_afull_i   (afull),
    .fifo_wr_dv_o   (dv),
    .fifo_wr_data_o (wdata),
    .grant_o        (grant),
    .grant_id_o     (gid),
    .busy_o         (busy)
  );

  int n_cmp = 0, n_err = 0;
  int m_grant = -1, m_beats = 0, m_ptr = 0;
  int seq[N], rx[N];
  int n_tx = 0, n_rx = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] v, input int ptr);
    for (int o = 0; o < N; o++) if (v[(ptr + o) % N]) return (ptr + o) % N;
    return -1;
  endfunction

  // One clock: drive at negedge, check combinational view, then advance model and scoreboard.
  task automatic step(input logic r, input logic [N-1:0] v, input logic f, input logic af, input bit en);
    logic [N-1:0] e_rdy;
    logic         e_dv;
    logic [W-1:0] e_dat;
    int           p;
    bit           done;
    @(negedge clk);
    rst = r; valid = v; full = f; afull = af;
    for (int k = 0; k < N; k++) data[k*W +: W] = {k[1:0], seq[k][5:0]};
    #1;
    e_rdy = '0;
    if (m_grant >= 0 && !f) e_rdy[m_grant] = 1'b1;
    e_dv  = |(v & e_rdy);
    e_dat = (m_grant >= 0) ? data[m_grant*W +: W] : '0;
    if (en) begin
      chk("ready", ready, e_rdy);
      chk("wr_dv", dv, e_dv);
      chk("wr_data", wdata, e_dat);
      chk("grant", grant, (m_grant >= 0) ? (1 << m_grant) : 0);
      chk("grant_id", gid, (m_grant >= 0) ? m_grant : 0);
      chk("busy", busy, m_grant >= 0);
    end
    for (int k = 0; k < N; k++) if (v[k] && ready[k]) begin seq[k]++; n_tx++; end
    if (dv) begin
      n_rx++;
      chk("write_while_full", f, 1'b0);
      chk("fifo_order", wdata[5:0], rx[wdata[7:6]][5:0]);
      rx[wdata[7:6]]++;
    end
    if (r) begin
      m_grant = -1; m_beats = 0; m_ptr = 0;
    end else begin
      done = m_grant < 0 || !v[m_grant] || (e_dv && m_beats == MB - 1);
      if (e_dv) m_beats++;
      if (done) begin
        p = pick(v, m_ptr);
        if (p >= 0 && !f && !af) begin m_grant = p; m_beats = 0; m_ptr = (p + 1) % N; end
        else m_grant = -1;
      end
    end
  endtask

  initial begin
    logic [N-1:0] rv;
    int wr0;
    rst = 1'b1; valid = '1; full = 1'b0; afull = 1'b0; data = '0;
    step(1'b1, '1, 1'b0, 1'b0, 1'b0);
    step(1'b1, '1, 1'b0, 1'b0, 1'b1);
    step(1'b1, '1, 1'b0, 1'b0, 1'b1);
    wr0 = n_rx;
    repeat (17) step(1'b0, '1, 1'b0, 1'b0, 1'b1);
    chk("writes_in_17", n_rx - wr0, 16);
    repeat (2) step(1'b0, '1, 1'b0, 1'b0, 1'b1);
    repeat (5) step(1'b0, '1, 1'b1, 1'b0, 1'b1);
    repeat (4) step(1'b0, '1, 1'b0, 1'b0, 1'b1);
    repeat (2) step(1'b0, 4'b0100, 1'b0, 1'b0, 1'b1);
    repeat (4) step(1'b0, 4'b1011, 1'b0, 1'b0, 1'b1);
    repeat (3) step(1'b0, '1, 1'b0, 1'b1, 1'b1);
    repeat (6) step(1'b0, '1, 1'b0, 1'b0, 1'b1);
    step(1'b1, '1, 1'b0, 1'b0, 1'b1);
    repeat (3) step(1'b0, '1, 1'b0, 1'b0, 1'b1);
    repeat (3000) begin
      for (int k = 0; k < N; k++) rv[k] = $urandom_range(3) != 0;
      step($urandom_range(99) == 0, rv, $urandom_range(9) == 0, $urandom_range(6) == 0, 1'b1);
    end
    chk("tx_eq_rx", n_rx, n_tx);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
